events_rate_window: RTL and testbench

// Multi-channel event-rate meter for the Sigma Delta DAQ. Counts per-channel event strobes

---
 rtl/events_rate_window.sv | 124 ++++++++++++
 tb/tb_events_rate_window.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/events_rate_window.sv
`default_nettype none
// ============================================================================
// Module      : events_rate_window
// Description : Multi-channel event-rate meter. It counts event strobes over a
//               programmable window and snapshots all channels at window end.
// Revision    : 1.0 - initial release
// ============================================================================
module events_rate_window #(
    parameter int CHANNEL_NUMBER = 2,
    parameter int COUNTER_LENGTH = 24,
    parameter int WINDOW_LENGTH  = 32,
    parameter bit SATURATE       = 1'b1
) (
    input  logic                                           clk,
    input  logic                                           reset,
    input  logic                                           clear,
    input  logic                                           start,
    input  logic                                           continuous,
    input  logic [WINDOW_LENGTH-1:0]                       window_value,
    input  logic [CHANNEL_NUMBER-1:0]                      enable,
    input  logic                                           read,
    output logic [CHANNEL_NUMBER-1:0][COUNTER_LENGTH-1:0]  event_count,
    output logic [CHANNEL_NUMBER-1:0]                      overflow,
    output logic                                           events_rate_ready,
    output logic                                           missed,
    output logic                                           busy
);

    typedef enum logic [0:0] {
        S_IDLE  = 1'b0,
        S_COUNT = 1'b1
    } state_t;

    localparam logic [WINDOW_LENGTH-1:0]  C_WIN_ONE = WINDOW_LENGTH'(1);
    localparam logic [COUNTER_LENGTH-1:0] C_CNT_ONE = COUNTER_LENGTH'(1);

    state_t                                        state_q;
    logic [WINDOW_LENGTH-1:0]                      win_len_q;
    logic [WINDOW_LENGTH-1:0]                      time_q;
    logic [CHANNEL_NUMBER-1:0][COUNTER_LENGTH-1:0] acc_q;
    logic [CHANNEL_NUMBER-1:0][COUNTER_LENGTH-1:0] acc_d;
    logic [CHANNEL_NUMBER-1:0]                     ovf_q;
    logic [CHANNEL_NUMBER-1:0]                     ovf_d;
    logic [WINDOW_LENGTH-1:0]                      win_len_d;
    logic                                          last_d;

    // A zero-length request would never terminate, so it runs as one cycle.
    assign win_len_d = (window_value == '0) ? C_WIN_ONE : window_value;
    assign last_d    = (state_q == S_COUNT) && (time_q == (win_len_q - C_WIN_ONE));
    assign busy      = (state_q == S_COUNT);

    // Accumulator value including this cycle's strobe, with saturate/wrap applied.
    always_comb begin
        acc_d = acc_q;
        ovf_d = ovf_q;
        for (int i = 0; i < CHANNEL_NUMBER; i++) begin
            if (enable[i]) begin
                if (&acc_q[i]) begin
                    ovf_d[i] = 1'b1;
                    acc_d[i] = SATURATE ? acc_q[i] : '0;
                end else begin
                    acc_d[i] = acc_q[i] + C_CNT_ONE;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            state_q           <= S_IDLE;
            win_len_q         <= '0;
            time_q            <= '0;
            acc_q             <= '0;
            ovf_q             <= '0;
            event_count       <= '0;
            overflow          <= '0;
            events_rate_ready <= 1'b0;
            missed            <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q   <= S_COUNT;
                        win_len_q <= win_len_d;
                        time_q    <= '0;
                        acc_q     <= '0;
                        ovf_q     <= '0;
                    end
                end
                S_COUNT: begin
                    if (last_d) begin
                        time_q <= '0;
                        acc_q  <= '0;
                        ovf_q  <= '0;
                        if (continuous) begin
                            win_len_q <= win_len_d;
                        end else begin
                            state_q <= S_IDLE;
                        end
                    end else begin
                        time_q <= time_q + C_WIN_ONE;
                        acc_q  <= acc_d;
                        ovf_q  <= ovf_d;
                    end
                end
                default: state_q <= S_IDLE;
            endcase

            // A snapshot takes precedence over a coincident read.
            if (last_d) begin
                event_count       <= acc_d;
                overflow          <= ovf_d;
                events_rate_ready <= 1'b1;
                if (events_rate_ready && !read) begin
                    missed <= 1'b1;
                end
            end else if (read) begin
                events_rate_ready <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_events_rate_window.sv
`default_nettype none
// ============================================================================
// Module      : tb_events_rate_window
// Description : Directed bench comparing three events_rate_window variants
//               against an integer window/event model every cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_events_rate_window;

    logic        clk = 1'b0;
    logic        reset, clear, start, continuous, read;
    logic [31:0] window_value;
    logic [1:0]  enable;

    logic [1:0][23:0] cnt0;
    logic [1:0][2:0]  cnt1, cnt2;
    logic [1:0]       ovf0, ovf1, ovf2;
    logic             rdy0, rdy1, rdy2, mis0, mis1, mis2, bsy0, bsy1, bsy2;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    events_rate_window #(.CHANNEL_NUMBER(2), .COUNTER_LENGTH(24), .WINDOW_LENGTH(32), .SATURATE(1'b1)) u_main (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .continuous(continuous),
        .window_value(window_value), .enable(enable), .read(read),
        .event_count(cnt0), .overflow(ovf0), .events_rate_ready(rdy0), .missed(mis0), .busy(bsy0));

    events_rate_window #(.CHANNEL_NUMBER(2), .COUNTER_LENGTH(3), .WINDOW_LENGTH(32), .SATURATE(1'b1)) u_sat (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .continuous(continuous),
        .window_value(window_value), .enable(enable), .read(read),
        .event_count(cnt1), .overflow(ovf1), .events_rate_ready(rdy1), .missed(mis1), .busy(bsy1));

    events_rate_window #(.CHANNEL_NUMBER(2), .COUNTER_LENGTH(3), .WINDOW_LENGTH(32), .SATURATE(1'b0)) u_wrap (
        .clk(clk), .reset(reset), .clear(clear), .start(start), .continuous(continuous),
        .window_value(window_value), .enable(enable), .read(read),
        .event_count(cnt2), .overflow(ovf2), .events_rate_ready(rdy2), .missed(mis2), .busy(bsy2));

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Per window: how many strobes each channel saw; the snapshot is derived
    // from that integer with the variant's saturate/wrap rule.
    bit      m_armed = 1'b0;
    bit      m_on, m_ready, m_missed;
    longint  m_len, m_t;
    longint  m_n[2];
    longint  m_cnt[3][2];
    bit      m_ovf[3][2];

    function automatic int cl_of(input int d);
        return (d == 0) ? 24 : 3;
    endfunction

    always @(posedge clk) begin : model
        bit     snap;
        longint mx;
        if (reset || clear) begin
            m_armed  = 1'b1;
            m_on     = 1'b0;
            m_ready  = 1'b0;
            m_missed = 1'b0;
            m_len    = 0;
            m_t      = 0;
            for (int c = 0; c < 2; c++) begin
                m_n[c] = 0;
                for (int d = 0; d < 3; d++) begin
                    m_cnt[d][c] = 0;
                    m_ovf[d][c] = 1'b0;
                end
            end
        end else if (m_armed) begin
            snap = 1'b0;
            if (m_on) begin
                for (int c = 0; c < 2; c++) m_n[c] += enable[c];
                m_t++;
                if (m_t == m_len) snap = 1'b1;
            end else if (start) begin
                m_on  = 1'b1;
                m_len = (window_value == 0) ? 1 : longint'(window_value);
                m_t   = 0;
                m_n[0] = 0;
                m_n[1] = 0;
            end
            if (snap) begin
                for (int d = 0; d < 3; d++) begin
                    mx = (longint'(1) <<< cl_of(d)) - 1;
                    for (int c = 0; c < 2; c++) begin
                        if (m_n[c] > mx) m_cnt[d][c] = (d == 2) ? (m_n[c] % (mx + 1)) : mx;
                        else             m_cnt[d][c] = m_n[c];
                        m_ovf[d][c] = (m_n[c] > mx);
                    end
                end
                if (m_ready && !read) m_missed = 1'b1;
                m_ready = 1'b1;
                m_n[0] = 0;
                m_n[1] = 0;
                m_t    = 0;
                if (continuous) m_len = (window_value == 0) ? 1 : longint'(window_value);
                else            m_on  = 1'b0;
            end else if (read) begin
                m_ready = 1'b0;
            end
        end
    end

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        if (m_armed) begin
            for (int c = 0; c < 2; c++) begin
                chk($sformatf("main.count[%0d]", c), cnt0[c], m_cnt[0][c]);
                chk($sformatf("sat.count[%0d]", c),  cnt1[c], m_cnt[1][c]);
                chk($sformatf("wrap.count[%0d]", c), cnt2[c], m_cnt[2][c]);
                chk($sformatf("main.ovf[%0d]", c),   ovf0[c], m_ovf[0][c]);
                chk($sformatf("sat.ovf[%0d]", c),    ovf1[c], m_ovf[1][c]);
                chk($sformatf("wrap.ovf[%0d]", c),   ovf2[c], m_ovf[2][c]);
            end
            chk("main.ready", rdy0, m_ready);
            chk("sat.ready",  rdy1, m_ready);
            chk("wrap.ready", rdy2, m_ready);
            chk("main.missed", mis0, m_missed);
            chk("sat.missed",  mis1, m_missed);
            chk("wrap.missed", mis2, m_missed);
            chk("main.busy", bsy0, m_on);
            chk("sat.busy",  bsy1, m_on);
            chk("wrap.busy", bsy2, m_on);
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse_read();
        read = 1'b1;
        tick(1);
        read = 1'b0;
    endtask

    initial begin
        reset = 1'b1; clear = 1'b0; start = 1'b0; continuous = 1'b0; read = 1'b0;
        window_value = 32'd0; enable = 2'b00;
        tick(2);
        chk("lit reset ready", rdy0, 0);
        chk("lit reset count0", cnt0[0], 0);
        reset = 1'b0;
        tick(1);

        // Window of 4, three strobes on channel 0 including the last cycle.
        window_value = 32'd4; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        enable = 2'b01;
        tick(3);
        enable = 2'b00;
        chk("lit w4 ready", rdy0, 1);
        chk("lit w4 count0", cnt0[0], 3);
        chk("lit w4 count1", cnt0[1], 0);
        chk("lit w4 ovf", ovf0, 0);
        pulse_read();
        chk("lit w4 ready after read", rdy0, 0);

        // Ten events: saturates at 7 / wraps to 2 in the 3-bit variants.
        window_value = 32'd10; start = 1'b1;
        tick(1);
        start = 1'b0; enable = 2'b01;
        tick(10);
        enable = 2'b00;
        chk("lit main 10", cnt0[0], 10);
        chk("lit sat 10", cnt1[0], 7);
        chk("lit sat ovf", ovf1[0], 1);
        chk("lit wrap 10", cnt2[0], 2);
        chk("lit wrap ovf", ovf2[0], 1);
        pulse_read();

        // Continuous windows of 8 with channel 0 held high.
        window_value = 32'd8; continuous = 1'b1; enable = 2'b01; start = 1'b1;
        tick(1);
        start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            tick(7);
            read = 1'b0;
            tick(1);
            chk("lit cont ready", rdy0, 1);
            chk("lit cont count", cnt0[0], 8);
            chk("lit cont busy", bsy0, 1);
            read = 1'b1;
        end
        tick(3);
        continuous = 1'b0; read = 1'b0;
        tick(5);
        chk("lit cont last count", cnt0[0], 8);
        chk("lit cont stop busy", bsy0, 0);
        enable = 2'b00;
        pulse_read();

        // Continuous window of 4, never read: second snapshot flags missed.
        window_value = 32'd4; continuous = 1'b1; start = 1'b1;
        tick(1);
        start = 1'b0; enable = 2'b01;
        tick(4);
        chk("lit miss first", cnt0[0], 4);
        tick(2);
        enable = 2'b00;
        tick(2);
        chk("lit miss newest", cnt0[0], 2);
        chk("lit missed", mis0, 1);
        tick(3);
        read = 1'b1;
        tick(1);
        read = 1'b0;
        chk("lit read on snapshot", rdy0, 1);
        continuous = 1'b0;
        tick(4);
        pulse_read();

        // Clear in the middle of a 10-cycle window.
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("lit clear missed", mis0, 0);
        window_value = 32'd10; start = 1'b1;
        tick(1);
        start = 1'b0; enable = 2'b11;
        tick(2);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        chk("lit clear busy", bsy0, 0);
        chk("lit clear count", cnt0[0], 0);
        tick(12);
        chk("lit clear no ready", rdy0, 0);
        window_value = 32'd3; start = 1'b1; enable = 2'b10;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("lit fresh count1", cnt0[1], 3);
        chk("lit fresh count0", cnt0[0], 0);
        enable = 2'b00;
        pulse_read();

        // Zero-length window runs one cycle; start seen while counting is ignored.
        window_value = 32'd0; enable = 2'b01; start = 1'b1;
        tick(2);
        start = 1'b0;
        chk("lit w0 count", cnt0[0], 1);
        chk("lit w0 busy", bsy0, 0);
        tick(1);
        pulse_read();
        window_value = 32'd5; start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        tick(3);
        chk("lit restart ignored", cnt0[0], 5);
        tick(6);
        chk("lit idle events", cnt0[0], 5);
        pulse_read();

        // Reset outranks a simultaneous clear and start.
        reset = 1'b1; clear = 1'b1; start = 1'b1;
        tick(1);
        reset = 1'b0; clear = 1'b0; start = 1'b0; enable = 2'b00;
        chk("lit reset priority busy", bsy0, 0);
        tick(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
